// File: rtl/multicycle_control.sv
// Multicycle LEGv8 sequencer: steps each instruction through fetch, decode,
// execute, memory and writeback, one state per clock. It drives the datapath
// enables and mux selects, stalls on the shared-memory ready handshake,
// aborts a stuck memory wait with a watchdog, and counts retired instructions.
//
// state      | enc | meaning
// -----------+-----+-----------------------------------------------------
// FETCH      |  0  | read instruction at PC; on ready load IR/OldPC, PC+=4
// DECODE     |  1  | classify Op, read register file
// MEM_ADDR   |  2  | ALU forms base + offset address for LDUR/STUR
// MEM_READ   |  3  | data read at ALU address, waits for ready
// MEM_WB     |  4  | write loaded data to register file, retire
// MEM_WRITE  |  5  | data write at ALU address, waits for ready, retire
// EXEC_R     |  6  | R-type ALU operation on two registers
// ALU_WB     |  7  | write ALU result to register file, retire
// BRANCH     |  8  | CBZ: pass B through ALU, take branch when Zero, retire
// 9..15      |  -  | unreachable; return to FETCH with all outputs low

module multicycle_control #(
    parameter int WAIT_MAX = 16,
    parameter int COUNT_W  = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [10:0]        Op,
    input  logic               Zero,
    input  logic               mem_ready,
    output logic               IRWrite,
    output logic               PCWrite,
    output logic               PCSrc,
    output logic               IorD,
    output logic               Reg2Loc,
    output logic               ALUSrc,
    output logic [1:0]         ALUOp,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               MemtoReg,
    output logic               RegWrite,
    output logic [3:0]         state,
    output logic               illegal,
    output logic               mem_error,
    output logic [COUNT_W-1:0] instr_count
);

    localparam int WCNT_W = $clog2(WAIT_MAX + 1);
    localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(WAIT_MAX - 1);

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXEC_R    = 4'd6,
        S_ALU_WB    = 4'd7,
        S_BRANCH    = 4'd8
    } state_t;

    typedef enum logic [2:0] {
        OP_LDUR,
        OP_STUR,
        OP_CBZ,
        OP_RTYPE,
        OP_ILLEGAL
    } op_class_t;

    state_t            state_q;
    state_t            state_d;
    op_class_t         op_class;
    logic [WCNT_W-1:0] wait_cnt;
    logic              in_wait;
    logic              xfer_done;
    logic              timeout;
    logic              retire;

    // Instruction class from the opcode field of IR.
    always_comb begin
        op_class = OP_ILLEGAL;
        casez (Op)
            11'b11111000010: op_class = OP_LDUR;
            11'b11111000000: op_class = OP_STUR;
            11'b10110100???: op_class = OP_CBZ;
            11'b1?001011000: op_class = OP_RTYPE;
            11'b10?01010000: op_class = OP_RTYPE;
            default:         op_class = OP_ILLEGAL;
        endcase
    end

    // Memory handshake and watchdog status for the three waiting states.
    always_comb begin
        in_wait   = (state_q == S_FETCH) || (state_q == S_MEM_READ) ||
                    (state_q == S_MEM_WRITE);
        xfer_done = in_wait && mem_ready;
        // The transfer wins a tie with the watchdog, so abort needs !mem_ready.
        timeout   = in_wait && !mem_ready && (wait_cnt == WAIT_LAST);
        retire    = (state_q == S_MEM_WB) || (state_q == S_ALU_WB) ||
                    (state_q == S_BRANCH) ||
                    ((state_q == S_MEM_WRITE) && mem_ready);
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (mem_ready) begin
                    state_d = S_DECODE;
                end else if (timeout) begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                case (op_class)
                    OP_LDUR, OP_STUR: state_d = S_MEM_ADDR;
                    OP_RTYPE:         state_d = S_EXEC_R;
                    OP_CBZ:           state_d = S_BRANCH;
                    default:          state_d = S_FETCH;
                endcase
            end
            S_MEM_ADDR: begin
                state_d = (op_class == OP_STUR) ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                if (mem_ready) begin
                    state_d = S_MEM_WB;
                end else if (timeout) begin
                    state_d = S_FETCH;
                end
            end
            S_MEM_WB:    state_d = S_FETCH;
            S_MEM_WRITE: begin
                if (mem_ready || timeout) begin
                    state_d = S_FETCH;
                end
            end
            S_EXEC_R:    state_d = S_ALU_WB;
            S_ALU_WB:    state_d = S_FETCH;
            S_BRANCH:    state_d = S_FETCH;
            default:     state_d = S_FETCH;
        endcase
    end

    // Datapath controls. Input-dependent strobes are gated by reset so that
    // only the FETCH read request is visible while reset is held.
    always_comb begin
        IRWrite   = 1'b0;
        PCWrite   = 1'b0;
        PCSrc     = 1'b0;
        IorD      = 1'b0;
        Reg2Loc   = 1'b0;
        ALUSrc    = 1'b0;
        ALUOp     = 2'b00;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        MemtoReg  = 1'b0;
        RegWrite  = 1'b0;
        illegal   = 1'b0;
        mem_error = 1'b0;
        case (state_q)
            S_FETCH: begin
                MemRead = 1'b1;
                if (reset && mem_ready) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                end
            end
            S_DECODE: begin
                Reg2Loc = (op_class == OP_STUR) || (op_class == OP_CBZ);
                illegal = reset && (op_class == OP_ILLEGAL);
            end
            S_MEM_ADDR: begin
                ALUSrc = 1'b1;
            end
            S_MEM_READ: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                ALUSrc  = 1'b1;
            end
            S_MEM_WB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            S_MEM_WRITE: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                ALUSrc   = 1'b1;
                Reg2Loc  = 1'b1;
            end
            S_EXEC_R: begin
                ALUOp = 2'b10;
            end
            S_ALU_WB: begin
                RegWrite = 1'b1;
                ALUOp    = 2'b10;
            end
            S_BRANCH: begin
                Reg2Loc = 1'b1;
                ALUOp   = 2'b01;
                PCSrc   = 1'b1;
                PCWrite = reset && Zero;
            end
            default: begin
            end
        endcase
        if (reset && timeout) begin
            mem_error = 1'b1;
        end
    end

    // Watchdog counter: restarts on every state change or abort, counts stall cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else if (timeout || (state_d != state_q)) begin
            wait_cnt <= '0;
        end else if (in_wait && !xfer_done) begin
            wait_cnt <= wait_cnt + WCNT_W'(1);
        end
    end

    // Retired-instruction counter, wraps silently.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_count <= '0;
        end else if (retire) begin
            instr_count <= instr_count + COUNT_W'(1);
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle state and control vectors
// are compared against hand-built constants.

module tb_multicycle_control;

    localparam int CW = 3;

    logic          clk;
    logic          reset;
    logic [10:0]   Op;
    logic          Zero;
    logic          mem_ready;
    logic          IRWrite, PCWrite, PCSrc, IorD, Reg2Loc, ALUSrc;
    logic [1:0]    ALUOp;
    logic          MemRead, MemWrite, MemtoReg, RegWrite;
    logic [3:0]    state;
    logic          illegal, mem_error;
    logic [CW-1:0] instr_count;
    logic [13:0]   outs;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_CBZ  = 11'b10110100101;
    localparam logic [10:0] OP_BAD  = 11'b00000000000;

    // IRWrite PCWrite PCSrc IorD Reg2Loc ALUSrc ALUOp MemRead MemWrite MemtoReg RegWrite illegal mem_error
    localparam logic [13:0] O_FETCH     = 14'b0_0_0_0_0_0_00_1_0_0_0_0_0;
    localparam logic [13:0] O_FETCH_RDY = 14'b1_1_0_0_0_0_00_1_0_0_0_0_0;
    localparam logic [13:0] O_DEC       = 14'b0_0_0_0_0_0_00_0_0_0_0_0_0;
    localparam logic [13:0] O_DEC_R2L   = 14'b0_0_0_0_1_0_00_0_0_0_0_0_0;
    localparam logic [13:0] O_DEC_ILL   = 14'b0_0_0_0_0_0_00_0_0_0_0_1_0;
    localparam logic [13:0] O_MADDR     = 14'b0_0_0_0_0_1_00_0_0_0_0_0_0;
    localparam logic [13:0] O_MREAD     = 14'b0_0_0_1_0_1_00_1_0_0_0_0_0;
    localparam logic [13:0] O_MWB       = 14'b0_0_0_0_0_0_00_0_0_1_1_0_0;
    localparam logic [13:0] O_MWRITE    = 14'b0_0_0_1_1_1_00_0_1_0_0_0_0;
    localparam logic [13:0] O_MWRITE_TO = 14'b0_0_0_1_1_1_00_0_1_0_0_0_1;
    localparam logic [13:0] O_EXEC      = 14'b0_0_0_0_0_0_10_0_0_0_0_0_0;
    localparam logic [13:0] O_ALUWB     = 14'b0_0_0_0_0_0_10_0_0_0_1_0_0;
    localparam logic [13:0] O_BR_TAKEN  = 14'b0_1_1_0_1_0_01_0_0_0_0_0_0;
    localparam logic [13:0] O_BR_NOT    = 14'b0_0_1_0_1_0_01_0_0_0_0_0_0;

    multicycle_control #(.WAIT_MAX(16), .COUNT_W(CW)) dut (
        .clk(clk), .reset(reset), .Op(Op), .Zero(Zero), .mem_ready(mem_ready),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .PCSrc(PCSrc), .IorD(IorD),
        .Reg2Loc(Reg2Loc), .ALUSrc(ALUSrc), .ALUOp(ALUOp), .MemRead(MemRead),
        .MemWrite(MemWrite), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .state(state), .illegal(illegal), .mem_error(mem_error),
        .instr_count(instr_count)
    );

    assign outs = {IRWrite, PCWrite, PCSrc, IorD, Reg2Loc, ALUSrc, ALUOp,
                   MemRead, MemWrite, MemtoReg, RegWrite, illegal, mem_error};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, check state and controls mid-cycle.
    task automatic cyc(input string tag, input logic rdy, input logic z,
                       input logic [3:0] es, input logic [13:0] eo);
        mem_ready = rdy;
        Zero      = z;
        @(negedge clk);
        check_val({tag, "_state"}, 32'(state), 32'(es));
        check_val({tag, "_outs"}, 32'(outs), 32'(eo));
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b0;
        Op        = OP_BAD;
        Zero      = 1'b0;
        mem_ready = 1'b1;
        @(negedge clk);
        check_val("rst_state", 32'(state), 32'd0);
        check_val("rst_outs", 32'(outs), 32'(O_FETCH));
        check_val("rst_count", 32'(instr_count), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // ADD, no stalls: 0,1,6,7
        Op = OP_ADD;
        cyc("add_f", 1'b1, 1'b0, 4'd0, O_FETCH_RDY);
        cyc("add_d", 1'b1, 1'b0, 4'd1, O_DEC);
        cyc("add_x", 1'b1, 1'b0, 4'd6, O_EXEC);
        cyc("add_w", 1'b1, 1'b0, 4'd7, O_ALUWB);
        check_val("add_count", 32'(instr_count), 32'd1);

        // LDUR with two stall cycles in MEM_READ
        Op = OP_LDUR;
        cyc("ld_f", 1'b1, 1'b0, 4'd0, O_FETCH_RDY);
        cyc("ld_d", 1'b1, 1'b0, 4'd1, O_DEC);
        cyc("ld_a", 1'b1, 1'b0, 4'd2, O_MADDR);
        cyc("ld_r0", 1'b0, 1'b0, 4'd3, O_MREAD);
        cyc("ld_r1", 1'b0, 1'b0, 4'd3, O_MREAD);
        cyc("ld_r2", 1'b1, 1'b0, 4'd3, O_MREAD);
        cyc("ld_wb", 1'b1, 1'b0, 4'd4, O_MWB);
        check_val("ld_count", 32'(instr_count), 32'd2);

        // CBZ taken then not taken
        Op = OP_CBZ;
        cyc("cbz1_f", 1'b1, 1'b1, 4'd0, O_FETCH_RDY);
        cyc("cbz1_d", 1'b1, 1'b1, 4'd1, O_DEC_R2L);
        cyc("cbz1_b", 1'b1, 1'b1, 4'd8, O_BR_TAKEN);
        cyc("cbz2_f", 1'b1, 1'b0, 4'd0, O_FETCH_RDY);
        cyc("cbz2_d", 1'b1, 1'b0, 4'd1, O_DEC_R2L);
        cyc("cbz2_b", 1'b1, 1'b0, 4'd8, O_BR_NOT);
        check_val("cbz_count", 32'(instr_count), 32'd4);

        // Illegal opcode
        Op = OP_BAD;
        cyc("ill_f", 1'b1, 1'b0, 4'd0, O_FETCH_RDY);
        cyc("ill_d", 1'b1, 1'b0, 4'd1, O_DEC_ILL);
        cyc("ill_ret", 1'b0, 1'b0, 4'd0, O_FETCH);
        check_val("ill_count", 32'(instr_count), 32'd4);

        // STUR watchdog abort on the 16th wait cycle; ready in DECODE is ignored
        Op = OP_STUR;
        cyc("sto_f", 1'b1, 1'b0, 4'd0, O_FETCH_RDY);
        cyc("sto_d", 1'b1, 1'b0, 4'd1, O_DEC_R2L);
        cyc("sto_a", 1'b0, 1'b0, 4'd2, O_MADDR);
        for (int i = 1; i <= 15; i++) cyc("sto_w", 1'b0, 1'b0, 4'd5, O_MWRITE);
        cyc("sto_abort", 1'b0, 1'b0, 4'd5, O_MWRITE_TO);
        cyc("sto_ret", 1'b0, 1'b0, 4'd0, O_FETCH);
        check_val("sto_count", 32'(instr_count), 32'd4);

        // STUR where ready arrives on the last allowed wait cycle: transfer wins
        cyc("stw_f", 1'b1, 1'b0, 4'd0, O_FETCH_RDY);
        cyc("stw_d", 1'b0, 1'b0, 4'd1, O_DEC_R2L);
        cyc("stw_a", 1'b0, 1'b0, 4'd2, O_MADDR);
        for (int i = 1; i <= 15; i++) cyc("stw_w", 1'b0, 1'b0, 4'd5, O_MWRITE);
        cyc("stw_last", 1'b1, 1'b0, 4'd5, O_MWRITE);
        check_val("stw_count", 32'(instr_count), 32'd5);

        // Three more ADDs wrap the 3-bit counter 5 -> 0
        Op = OP_ADD;
        for (int i = 0; i < 3; i++) begin
            cyc("wrap_f", 1'b1, 1'b0, 4'd0, O_FETCH_RDY);
            cyc("wrap_d", 1'b1, 1'b0, 4'd1, O_DEC);
            cyc("wrap_x", 1'b1, 1'b0, 4'd6, O_EXEC);
            cyc("wrap_w", 1'b1, 1'b0, 4'd7, O_ALUWB);
        end
        check_val("wrap_count", 32'(instr_count), 32'd0);

        // One more retire so the reset-clears-count check is meaningful
        cyc("pre_f", 1'b1, 1'b0, 4'd0, O_FETCH_RDY);
        cyc("pre_d", 1'b1, 1'b0, 4'd1, O_DEC);
        cyc("pre_x", 1'b1, 1'b0, 4'd6, O_EXEC);
        cyc("pre_w", 1'b1, 1'b0, 4'd7, O_ALUWB);
        check_val("pre_count", 32'(instr_count), 32'd1);

        // Async reset in the middle of MEM_WRITE
        Op = OP_STUR;
        cyc("ar_f", 1'b1, 1'b0, 4'd0, O_FETCH_RDY);
        cyc("ar_d", 1'b1, 1'b0, 4'd1, O_DEC_R2L);
        cyc("ar_a", 1'b0, 1'b0, 4'd2, O_MADDR);
        @(negedge clk);
        check_val("ar_memwrite_before", 32'(MemWrite), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check_val("ar_memwrite_after", 32'(MemWrite), 32'd0);
        check_val("ar_state", 32'(state), 32'd0);
        check_val("ar_count", 32'(instr_count), 32'd0);
        check_val("ar_outs", 32'(outs), 32'(O_FETCH));
        @(posedge clk);
        #1;
        check_val("ar_hold_state", 32'(state), 32'd0);
        reset = 1'b1;
        Op = OP_ADD;
        cyc("ar_rf", 1'b1, 1'b0, 4'd0, O_FETCH_RDY);
        cyc("ar_rd", 1'b1, 1'b0, 4'd1, O_DEC);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
